// File: rtl/jsv_pkg.sv
// Shared types and defaults for the fractal-to-SDRAM pixel write path.
package jsv_pkg;

    localparam int unsigned DEF_H_RES = 640;
    localparam int unsigned DEF_V_RES = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] intensity;
    } pix_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    // Byte offset of a 16-bit pixel from the top-left of the bitmap.
    function automatic logic [31:0] pix_byte_offset(
        input logic [9:0]  x,
        input logic [8:0]  y,
        input int unsigned h_res
    );
        logic [18:0] row_base;
        row_base = 19'(32'(y) * h_res);
        return (32'(row_base) + 32'(x)) << 1;
    endfunction

endpackage

// File: rtl/pixel_write_buffer_sync_fifo.sv
// Synchronous FIFO with occupancy count; head entry is read straight from the array.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: it is only read while level is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers computed pixels and writes them to the SDRAM bitmap over Avalon-MM,
// dropping off-screen pixels and flagging completion of the last pixel of a frame.
module pixel_write_buffer
    import jsv_pkg::*;
#(
    parameter  int unsigned H_RES      = DEF_H_RES,
    parameter  int unsigned V_RES      = DEF_V_RES,
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  logic [31:0] BASE_ADDR  = 32'd0,
    parameter  int unsigned ADDR_W     = 24,
    localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [15:0]       x_draw,
    input  logic [15:0]       y_draw,
    input  logic [8:0]        intensity,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [15:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              frame_done,
    output logic [15:0]       drop_count,
    output logic [LW-1:0]     fifo_level
);

    wb_state_t         state_q, state_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              last_q, last_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       drop_q, drop_d;

    pix_entry_t        pix_in;
    pix_entry_t        head;
    logic [$bits(pix_entry_t)-1:0] fifo_dout;
    logic [LW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              accept;
    logic              in_range;

    // Level counts the entry held on the bus so that back-pressure covers it too.
    assign avm_write  = (state_q == WRITE);
    assign fifo_level = fifo_cnt + LW'(avm_write);
    assign pix_ready  = run_q && (fifo_level < LW'(FIFO_DEPTH));

    assign in_range = !x_draw[15] && (x_draw < 16'(H_RES)) &&
                      !y_draw[15] && (y_draw < 16'(V_RES));
    assign accept    = pix_valid && pix_ready;
    assign fifo_push = accept && in_range;

    always_comb begin
        pix_in           = '0;
        pix_in.x         = x_draw[9:0];
        pix_in.y         = y_draw[8:0];
        pix_in.intensity = intensity;
    end

    assign head = pix_entry_t'(fifo_dout);

    sync_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (fifo_push),
        .din   (pix_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (fifo_cnt),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        run_d        = 1'b1;
        drop_d       = drop_q;

        if (accept && !in_range && (drop_q != '1)) drop_d = drop_q + 16'd1;

        // A completed write and the next pop share a cycle to sustain one write per clock.
        if (state_q == WRITE && !avm_waitrequest) begin
            frame_done_d = last_q;
            if (fifo_empty) state_d = IDLE;
        end
        if (!fifo_empty && (state_q == IDLE || !avm_waitrequest)) begin
            fifo_pop = 1'b1;
            state_d  = WRITE;
            addr_d   = ADDR_W'(BASE_ADDR + pix_byte_offset(head.x, head.y, H_RES));
            data_d   = {7'b0, head.intensity};
            last_d   = (head.x == 10'(H_RES - 1)) && (head.y == 9'(V_RES - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_writedata = data_q;
    assign frame_done    = frame_done_q;
    assign drop_count    = drop_q;

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Sits directly downstream of fractal_calc and upstream of the SDRAM bitmap port in the VGA interface.
- Accepts one computed pixel per handshake: screen x/y and escape-iteration intensity.
- Buffers pixels in a small FIFO so calc stalls only when the buffer is full.
- Converts each pixel to an SDRAM byte address and issues Avalon-MM writes honouring waitrequest; flags frame completion and drops off-screen pixels.

Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- FIFO_DEPTH, 16, pixel entries buffered (power of 2, ≥2)
- BASE_ADDR, 0, byte address of pixel (0,0)
- ADDR_W, 24, Avalon address width

Ports:
- CLK  in  1  system clock (50 MHz)
- RESET_N  in  1  synchronous active-low reset
- pix_valid  in  1  calc presents a pixel
- pix_ready  out  1  buffer accepts pixel this cycle
- x_draw  in  16  signed screen x
- y_draw  in  16  signed screen y
- intensity  in  9  iteration count / colour index
- avm_address  out  ADDR_W  byte address of write
- avm_write  out  1  write request
- avm_writedata  out  16  {7'b0, intensity}
- avm_waitrequest  in  1  slave stall
- frame_done  out  1  one-cycle pulse after pixel (H_RES-1,V_RES-1) write is accepted
- drop_count  out  16  off-screen pixels discarded since reset
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- All state updates occur on CLK rising edge. RESET_N=0 sampled on an edge clears the FIFO pointers and level and forces: pix_ready=0, avm_write=0, avm_address=0, avm_writedata=0, frame_done=0, drop_count=0, state=IDLE.
- Reset mid-transaction abandons the in-flight write without completing it. pix_ready rises on the first cycle after reset release.
- Input handshake: a pixel is accepted when pix_valid & pix_ready.
  - pix_ready = (fifo_level < FIFO_DEPTH) & ~reset, combinational from registered level.
  - pix_ready does not depend on pix_valid.
- Range check at acceptance: a pixel with x<0, x≥H_RES, y<0 or y≥V_RES is consumed but not stored.
  - drop_count increments by 1 and saturates at 16'hFFFF.
- Stored entry: {x[9:0], y[8:0], intensity}. Address is computed at pop time: BASE_ADDR + 2*(y*H_RES + x), truncated to ADDR_W.
  - Multiply uses an unsigned 19-bit product; no overflow is possible for the default parameters.
- Write FSM states: IDLE and WRITE.
  - IDLE: if FIFO is non-empty, pop the head, register address and data, set avm_write=1, go to WRITE. Minimum latency is 1 cycle from push into an empty FIFO to avm_write=1.
  - WRITE: hold avm_address, avm_write and avm_writedata stable while avm_waitrequest=1.
  - WRITE, on waitrequest=0 with FIFO non-empty: the write completes; pop the next entry and stay in WRITE (back-to-back, 1 write per cycle).
  - WRITE, on waitrequest=0 with FIFO empty: deassert avm_write and return to IDLE.
- frame_done pulses in the cycle after the accepted write whose coordinates are (H_RES-1,V_RES-1). It is independent of write order.
- Simultaneous push and pop: level is unchanged, and a full FIFO accepts a push in the same cycle a pop frees a slot only on the following cycle. pix_ready uses the registered level, so there is no combinational path from avm_waitrequest.
- Pointers wrap modulo FIFO_DEPTH. Empty/full are derived from fifo_level, never from pointer equality alone.
- avm_write is never asserted with X data. Order is preserved: writes are issued in acceptance order.

Decomposition:
- Shared package jsv_pkg holds:
  - H_RES/V_RES defaults
  - the pix_entry_t packed struct {x, y, intensity}
  - the state enum wb_state_t {IDLE, WRITE}
- One sub-module: sync_fifo (parameterised width/depth, push/pop/level; registered outputs and the same synchronous active-low reset).
- Address arithmetic and the FSM live in pixel_write_buffer.

Test Plan:
- Single pixel (x=3,y=2,i=9) into empty buffer, waitrequest=0 -> avm_write=1 one cycle later with address 2*(2*640+3)=2566, writedata=0x0009, then avm_write=0.
- Push 16 pixels with waitrequest held 1 -> pix_ready=0 after 16th acceptance, fifo_level=16 (one entry in flight: level reads 15 plus held write), address and data stable; release waitrequest -> 16 back-to-back writes in push order.
- Pixels (-1,0), (640,5), (0,480) -> no avm_write, drop_count=3; then (639,479,i=1) -> address 614398, frame_done pulses once.
- Waitrequest toggling 1,0,1,0 during a 4-pixel burst -> each write is held until a waitrequest=0 cycle; exactly 4 writes are observed with no duplicates or skips.
- Assert RESET_N=0 for 1 cycle mid-burst with 5 entries queued -> next cycle avm_write=0, fifo_level=0, drop_count=0, pix_ready=0; one cycle after release pix_ready=1 and no stale writes follow.
- Random valid/waitrequest for 10k pixels against a scoreboard -> written sequence equals accepted in-range sequence, and drop_count matches the number of off-screen inputs.
